// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game controller: random arm delay, stimulus lamp,
// reaction measurement in ms with foul and timeout detection.
module reaction_timer_ctrl #(
    parameter int COUNT_BITS      = 14,
    parameter int DELAY_MIN_MS    = 1000,
    parameter int DELAY_RAND_BITS = 12,
    parameter int TIMEOUT_MS      = 9999
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick_ms,
    input  logic                  start,
    input  logic                  react,
    output logic                  led,
    output logic                  cnt_reset,
    output logic                  cnt_stop,
    output logic [COUNT_BITS-1:0] result_ms,
    output logic [1:0]            status
);

    localparam int DW = $clog2(DELAY_MIN_MS + 2**DELAY_RAND_BITS + 1);
    localparam logic [COUNT_BITS-1:0] TMO    = COUNT_BITS'(TIMEOUT_MS);
    localparam logic [COUNT_BITS-1:0] TMO_M1 = COUNT_BITS'(TIMEOUT_MS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        GO,
        DONE,
        FOUL,
        TOUT
    } state_t;

    state_t state;
    state_t next;

    logic            start_q;
    logic            react_q;
    logic            edge_en;
    logic            start_edge;
    logic            react_edge;
    logic [15:0]     lfsr;
    logic [DW-1:0]   delay_cnt;
    logic [DW-1:0]   delay_load;
    logic [COUNT_BITS-1:0] elapsed;
    logic            expiry;
    logic            timeout_hit;
    logic            arm_enter;
    logic            go_enter;
    logic            go_leave;

    // edge_en masks the first clk after reset so a held button is not an edge
    assign start_edge = start & ~start_q & edge_en;
    assign react_edge = react & ~react_q & edge_en;

    assign delay_load  = DW'(DELAY_MIN_MS) + DW'(lfsr[DELAY_RAND_BITS-1:0]);
    assign expiry      = tick_ms && (delay_cnt <= DW'(1));
    assign timeout_hit = tick_ms && (elapsed >= TMO_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            react_q <= 1'b0;
            edge_en <= 1'b0;
            lfsr    <= 16'hACE1;
        end else begin
            start_q <= start;
            react_q <= react;
            edge_en <= 1'b1;
            lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE, DONE, FOUL, TOUT: begin
                if (start_edge) next = ARM;
            end
            ARM: begin
                if (react_edge) next = FOUL;
                else if (expiry) next = GO;
            end
            GO: begin
                if (react_edge) next = DONE;
                else if (timeout_hit) next = TOUT;
            end
            default: next = IDLE;
        endcase
    end

    always_comb begin
        led       = (state == GO);
        arm_enter = (next == ARM) && (state != ARM);
        go_enter  = (next == GO) && (state != GO);
        go_leave  = (state == GO) && (next != GO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_cnt <= '0;
            elapsed   <= '0;
        end else begin
            if (arm_enter) begin
                delay_cnt <= delay_load;
            end else if (state == ARM && tick_ms && delay_cnt != '0) begin
                delay_cnt <= delay_cnt - 1'b1;
            end
            if (go_enter) begin
                elapsed <= '0;
            end else if (state == GO && tick_ms && elapsed != TMO) begin
                elapsed <= elapsed + 1'b1;
            end
        end
    end

    // strobes stay up until the counter has seen exactly one tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reset <= 1'b0;
            cnt_stop  <= 1'b0;
        end else begin
            if (go_enter) cnt_reset <= 1'b1;
            else if (tick_ms) cnt_reset <= 1'b0;
            if (go_leave) cnt_stop <= 1'b1;
            else if (tick_ms) cnt_stop <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_ms <= '0;
            status    <= 2'b00;
        end else begin
            if (arm_enter) begin
                status <= 2'b00;
            end else if (state == ARM && next == FOUL) begin
                status    <= 2'b10;
                result_ms <= '0;
            end else if (state == GO && next == DONE) begin
                status    <= 2'b01;
                result_ms <= elapsed;
            end else if (state == GO && next == TOUT) begin
                status    <= 2'b11;
                result_ms <= TMO;
            end
        end
    end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Scoreboard bench for reaction_timer_ctrl: directed rounds push expected
// events, a negedge monitor observes DUT outputs and compares.
module tb_reaction_timer_ctrl;

    localparam int CB   = 14;
    localparam int DMIN = 1490;
    localparam int RB   = 4;
    localparam int TMO  = 9999;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick_ms = 1'b0;
    logic          start = 1'b0;
    logic          react = 1'b0;
    logic          led;
    logic          cnt_reset;
    logic          cnt_stop;
    logic [CB-1:0] result_ms;
    logic [1:0]    status;

    reaction_timer_ctrl #(
        .COUNT_BITS(CB),
        .DELAY_MIN_MS(DMIN),
        .DELAY_RAND_BITS(RB),
        .TIMEOUT_MS(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tick_ms(tick_ms),
        .start(start),
        .react(react),
        .led(led),
        .cnt_reset(cnt_reset),
        .cnt_stop(cnt_stop),
        .result_ms(result_ms),
        .status(status)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // event kinds: 0 led rise (global tick count), 1 cnt_reset window ticks,
    // 2 result (status*65536+result_ms), 3 cnt_stop window ticks
    typedef struct {
        int kind;
        int val;
    } ev_t;
    ev_t exq[$];

    task automatic expect_ev(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exq.push_back(e);
    endtask

    task automatic observe(input int kind, input int val);
        ev_t e;
        if (exq.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event kind %0d: got %0d expected none", kind, val);
        end else begin
            e = exq.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_value", val, e.val);
        end
    endtask

    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    int   mon_ticks = 0;
    int   rw = 0;
    int   sw = 0;
    logic led_p = 1'b0;
    logic crst_p = 1'b0;
    logic cstp_p = 1'b0;
    logic [1:0] st_p = 2'b00;

    always @(negedge clk) begin
        if (!rst_n) begin
            rw = 0;
            sw = 0;
            led_p = 1'b0;
            crst_p = 1'b0;
            cstp_p = 1'b0;
            st_p = 2'b00;
        end else begin
            if (led && !led_p) observe(0, mon_ticks);
            if (crst_p && !cnt_reset) begin
                observe(1, rw);
                rw = 0;
            end
            if (st_p == 2'b00 && status != 2'b00)
                observe(2, int'(status) * 65536 + int'(result_ms));
            if (cstp_p && !cnt_stop) begin
                observe(3, sw);
                sw = 0;
            end
            if (cnt_reset && tick_ms) rw++;
            if (cnt_stop && tick_ms) sw++;
            led_p = led;
            crst_p = cnt_reset;
            cstp_p = cnt_stop;
            st_p = status;
        end
        if (tick_ms) mon_ticks++;
    end

    int gt = 0;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            tick_ms = 1'b1;
            gt++;
            cyc(1);
            tick_ms = 1'b0;
            cyc(1);
        end
    endtask

    task automatic press_start(output int dly);
        dly = DMIN + int'(m_lfsr[RB-1:0]);
        start = 1'b1;
        cyc(1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_led"}, int'(led), 0);
        chk({tag, "_cnt_reset"}, int'(cnt_reset), 0);
        chk({tag, "_cnt_stop"}, int'(cnt_stop), 0);
        chk({tag, "_result"}, int'(result_ms), 0);
        chk({tag, "_status"}, int'(status), 0);
    endtask

    initial begin
        int d;
        int k;
        rst_n = 1'b0;
        cyc(3);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        cyc(2);

        // round 1: time the press so the delay load is exactly 1500
        k = 0;
        while (m_lfsr[RB-1:0] != 4'd10 && k < 1000) begin
            cyc(1);
            k++;
        end
        chk("lfsr_align", int'(m_lfsr[RB-1:0]), 10);
        press_start(d);
        start = 1'b0;
        chk("delay_load", d, 1500);
        expect_ev(0, gt + d);
        expect_ev(1, 1);
        tick(d);
        tick(237);
        expect_ev(2, 1 * 65536 + 237);
        expect_ev(3, 1);
        react = 1'b1;
        cyc(1);
        chk("led_after_done", int'(led), 0);
        tick(2);
        react = 1'b0;
        cyc(1);

        // round 2a: early foul
        press_start(d);
        start = 1'b0;
        tick(5);
        expect_ev(2, 2 * 65536);
        react = 1'b1;
        cyc(1);
        react = 1'b0;
        tick(2);
        chk("foul_led", int'(led), 0);

        // round 2b: react in the same clk as the expiry tick
        press_start(d);
        start = 1'b0;
        tick(d - 1);
        expect_ev(2, 2 * 65536);
        tick_ms = 1'b1;
        react = 1'b1;
        gt++;
        cyc(1);
        tick_ms = 1'b0;
        react = 1'b0;
        cyc(1);
        tick(3);
        chk("expiry_foul_led", int'(led), 0);
        chk("expiry_foul_cnt_reset", int'(cnt_reset), 0);

        // round 3: timeout
        press_start(d);
        start = 1'b0;
        expect_ev(0, gt + d);
        expect_ev(1, 1);
        tick(d);
        expect_ev(2, 3 * 65536 + TMO);
        expect_ev(3, 1);
        tick(TMO);
        chk("timeout_led", int'(led), 0);
        tick(2);

        // round 4: react in the expiry clk wins
        press_start(d);
        start = 1'b0;
        expect_ev(0, gt + d);
        expect_ev(1, 1);
        tick(d);
        tick(TMO - 1);
        expect_ev(2, 1 * 65536 + TMO - 1);
        expect_ev(3, 1);
        tick_ms = 1'b1;
        react = 1'b1;
        gt++;
        cyc(1);
        tick_ms = 1'b0;
        cyc(1);
        tick(2);
        react = 1'b0;
        cyc(1);

        // round 5: reset in GO with react and start held across release
        press_start(d);
        start = 1'b0;
        expect_ev(0, gt + d);
        expect_ev(1, 1);
        tick(d);
        tick(10);
        rst_n = 1'b0;
        react = 1'b1;
        start = 1'b1;
        #1;
        chk_idle_outputs("mid_reset");
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        tick(5);
        react = 1'b0;
        cyc(1);
        react = 1'b1;
        cyc(2);
        tick(3);
        chk("post_reset_status", int'(status), 0);
        chk("post_reset_led", int'(led), 0);
        react = 1'b0;
        start = 1'b0;
        cyc(2);

        // round 6: start held across DONE, then re-pressed; press in ARM ignored
        press_start(d);
        expect_ev(0, gt + d);
        expect_ev(1, 1);
        tick(d);
        tick(50);
        expect_ev(2, 1 * 65536 + 50);
        expect_ev(3, 1);
        react = 1'b1;
        cyc(1);
        react = 1'b0;
        tick(2);
        cyc(3);
        tick(3);
        chk("hold_status", int'(status), 1);
        chk("hold_result", int'(result_ms), 50);
        start = 1'b0;
        cyc(2);
        press_start(d);
        start = 1'b0;
        expect_ev(0, gt + d);
        expect_ev(1, 1);
        tick(10);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        tick(d - 10);
        tick(3);
        expect_ev(2, 1 * 65536 + 3);
        expect_ev(3, 1);
        react = 1'b1;
        cyc(1);
        react = 1'b0;
        tick(2);

        cyc(4);
        chk("queue_empty", exq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reaction_timer_ctrl.md
REACTION_TIMER_CTRL -- requirements
Module: reaction_timer_ctrl

Interface
REQ-001 SHALL have parameter COUNT_BITS, default 14, width of result_ms and of the downstream reaction counter.
REQ-002 SHALL have parameter DELAY_MIN_MS, default 1000, minimum random wait before the stimulus, in ms.
REQ-003 SHALL have parameter DELAY_RAND_BITS, default 12, number of LFSR bits added to DELAY_MIN_MS.
REQ-004 SHALL have parameter TIMEOUT_MS, default 9999, maximum reaction time; must be less than 2^COUNT_BITS.
REQ-005 SHALL have one clock and an asynchronous, active-low reset; clk, rst_n.
REQ-006 SHALL have port clk  input  1  system clock, all state changes on its rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port tick_ms  input  1  one-clk-wide enable pulse, once per ms.
REQ-009 SHALL have port start  input  1  debounced start button, level, active-high.
REQ-010 SHALL have port react  input  1  debounced reaction button, level, active-high.
REQ-011 SHALL have port led  output  1  stimulus lamp, high while the FSM is in GO.
REQ-012 SHALL have port cnt_reset  output  1  reset/start strobe to the ms reaction counter.
REQ-013 SHALL have port cnt_stop  output  1  stop strobe to the ms reaction counter.
REQ-014 SHALL have port result_ms  output  COUNT_BITS  latched reaction time in ms.
REQ-015 SHALL have port status  output  2  00 none, 01 valid, 10 foul (early press), 11 timeout.

Function
REQ-016 SHALL detect rising edges of start and react using one registered copy of each; levels held high SHALL NOT retrigger.
REQ-017 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11) advancing every clk, reset seed 16'hACE1, never all-zero.
REQ-018 SHALL implement states IDLE, ARM, GO, DONE, FOUL, TOUT.
REQ-019 IDLE/DONE/FOUL/TOUT: start edge -> ARM; delay counter loads DELAY_MIN_MS + lfsr[DELAY_RAND_BITS-1:0]; status <= 00.
REQ-020 ARM: delay counter decrements on each tick_ms; on a tick with the counter at 1 -> GO.
REQ-021 ARM: react edge -> FOUL, status <= 10, result_ms <= 0; react edge in the same clk as the expiry tick SHALL give FOUL.
REQ-022 GO entry: led <= 1, elapsed <= 0, and cnt_reset asserted from that clk until the clk after the next tick_ms (exactly one tick sample).
REQ-023 GO: elapsed increments on each tick_ms, saturating at TIMEOUT_MS.
REQ-024 GO: react edge -> DONE, result_ms <= elapsed (tick in the same clk excluded), status <= 01.
REQ-025 GO: tick taking elapsed to TIMEOUT_MS with no react edge -> TOUT, result_ms <= TIMEOUT_MS, status <= 11; react in that same clk wins (DONE).
REQ-026 leaving GO: led <= 0 and cnt_stop asserted for one tick window, as in REQ-022.
REQ-027 start edges in ARM or GO SHALL be ignored.
REQ-028 result_ms and status SHALL hold until the next start edge.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, led=0, cnt_reset=0, cnt_stop=0, result_ms=0, status=00, counters=0, LFSR=16'hACE1, edge registers=0.
REQ-030 Reset mid-round (ARM or GO) SHALL abort with no strobe emitted; a button held across reset release SHALL NOT count as an edge.

Verification
REQ-031 Reset, LFSR forced, delay load 1500; start edge -> led rises exactly at the 1500th tick; cnt_reset spans exactly one tick.
REQ-032 In GO, react edge after 237 ticks -> status=01, result_ms=237, led=0, one cnt_stop window.
REQ-033 react edge in ARM -> status=10, result_ms=0, led never asserted, no cnt_reset.
REQ-034 No react in GO -> at tick 9999 status=11, result_ms=9999; react in the expiry clk -> status=01, result_ms=9998.
REQ-035 rst_n low during GO with react held -> IDLE, all outputs 0; on release no edge detected and FSM stays in IDLE.
REQ-036 start held high across DONE, then re-pressed -> exactly one new round; start pressed during ARM -> ignored.
